// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default bit timing, frame result
// record and the parity helper also used by the transmitter.
package uart_pkg;

    localparam int TAKTY_DOMYSLNE = 16;

    localparam logic [2:0] BEZCZYNNY  = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] DANE       = 3'd2;
    localparam logic [2:0] PARZYSTOSC = 3'd3;
    localparam logic [2:0] STOP       = 3'd4;
    localparam logic [2:0] CZEKAJ_WYS = 3'd5;

    typedef struct packed {
        logic [7:0] slowo;
        logic       blad_parz;
        logic       blad_ramki;
    } wynik_t;

    // Parity bit a transmitter must send: even -> XOR of data, odd -> its inverse.
    function automatic logic bit_parzystosci(input logic [7:0] dane, input logic parzysta);
        return (^dane) ^ ~parzysta;
    endfunction

endpackage

// File: rtl/uart_zegar_bitu.sv
// Bit-period counter: strobes at mid start bit (i_polowa) or once per full bit period,
// restarting from zero whenever i_kasuj is asserted.
module uart_zegar_bitu #(
    parameter int TAKTY_NA_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_kasuj,
    input  logic i_polowa,
    output logic o_probka
);

    localparam int SZER = $clog2(TAKTY_NA_BIT);
    localparam logic [SZER-1:0] OSTATNI = SZER'(TAKTY_NA_BIT - 1);
    localparam logic [SZER-1:0] POLOWA  = SZER'(TAKTY_NA_BIT / 2 - 1);

    logic [SZER-1:0] r_licznik;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_kasuj) begin
            r_licznik <= '0;
        end else if (r_licznik == OSTATNI) begin
            r_licznik <= '0;
        end else begin
            r_licznik <= r_licznik + 1'b1;
        end
    end

    assign o_probka = (r_licznik == (i_polowa ? POLOWA : OSTATNI));

endmodule

// File: rtl/uart_odbiornik.sv
// UART receiver (8 data bits, optional parity, 1 stop); odebrano pulses (9.5+P)*TAKTY_NA_BIT+S+1
// cycles after the start edge. UART_ODB_SYNC_EN adds a 2-flop input synchroniser (S=2).
module uart_odbiornik
    import uart_pkg::*;
#(
    parameter int TAKTY_NA_BIT = TAKTY_DOMYSLNE
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wejscie_odb,
    input  logic       i_czy_parz,
    input  logic       i_jaki_parz,
    output logic [7:0] o_slowo_odb,
    output logic       o_odebrano,
    output logic       o_blad_parz,
    output logic       o_blad_ramki,
    output logic       o_odbior
);

    logic       w_linia;
    logic       w_spadek;
    logic       w_probka;
    logic       w_kasuj;
    logic [2:0] w_stan_nast;

    logic [2:0] r_stan;
    logic       r_poprz;
    logic       r_czy_parz;
    logic       r_jaki_parz;
    logic [7:0] r_rej;
    logic [2:0] r_nr_bitu;
    logic       r_bit_parz;
    logic       r_odebrano;
    wynik_t     r_wynik;

`ifdef UART_ODB_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_wejscie_odb;
            r_sync2 <= r_sync1;
        end
    end

    assign w_linia = r_sync2;
`else
    assign w_linia = i_wejscie_odb;
`endif

    assign w_spadek = r_poprz & ~w_linia;
    // Counter restarts on every state entry so each sample lands mid-bit.
    assign w_kasuj  = (r_stan == BEZCZYNNY) || (w_stan_nast != r_stan);

    uart_zegar_bitu #(
        .TAKTY_NA_BIT(TAKTY_NA_BIT)
    ) u_zegar (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_kasuj (w_kasuj),
        .i_polowa(r_stan == START),
        .o_probka(w_probka)
    );

    always_comb begin
        w_stan_nast = r_stan;
        case (r_stan)
            BEZCZYNNY:  if (w_spadek) w_stan_nast = START;
            START:      if (w_probka) w_stan_nast = w_linia ? BEZCZYNNY : DANE;
            DANE:       if (w_probka && (r_nr_bitu == 3'd7)) w_stan_nast = r_czy_parz ? PARZYSTOSC : STOP;
            PARZYSTOSC: if (w_probka) w_stan_nast = STOP;
            STOP:       if (w_probka) w_stan_nast = w_linia ? BEZCZYNNY : CZEKAJ_WYS;
            CZEKAJ_WYS: if (w_linia) w_stan_nast = BEZCZYNNY;
            default:    w_stan_nast = BEZCZYNNY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stan      <= BEZCZYNNY;
            r_poprz     <= 1'b1;
            r_czy_parz  <= 1'b0;
            r_jaki_parz <= 1'b0;
            r_rej       <= 8'h00;
            r_nr_bitu   <= 3'd0;
            r_bit_parz  <= 1'b0;
            r_odebrano  <= 1'b0;
            r_wynik     <= '0;
        end else begin
            r_stan     <= w_stan_nast;
            r_poprz    <= w_linia;
            r_odebrano <= 1'b0;
            case (r_stan)
                BEZCZYNNY: begin
                    if (w_spadek) begin
                        r_czy_parz  <= i_czy_parz;
                        r_jaki_parz <= i_jaki_parz;
                        r_nr_bitu   <= 3'd0;
                        r_bit_parz  <= 1'b0;
                    end
                end
                DANE: begin
                    if (w_probka) begin
                        r_rej     <= {w_linia, r_rej[7:1]};
                        r_nr_bitu <= r_nr_bitu + 3'd1;
                    end
                end
                PARZYSTOSC: begin
                    if (w_probka) r_bit_parz <= w_linia;
                end
                STOP: begin
                    if (w_probka) begin
                        r_wynik.slowo      <= r_rej;
                        r_wynik.blad_parz  <= r_czy_parz &&
                                              (r_bit_parz != bit_parzystosci(r_rej, r_jaki_parz));
                        r_wynik.blad_ramki <= ~w_linia;
                        r_odebrano         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_slowo_odb  = r_wynik.slowo;
    assign o_blad_parz  = r_wynik.blad_parz;
    assign o_blad_ramki = r_wynik.blad_ramki;
    assign o_odebrano   = r_odebrano;
    assign o_odbior     = (r_stan != BEZCZYNNY);

endmodule

// File: tb/tb_uart_odbiornik.sv
// Self-checking bench for uart_odbiornik: a frame-level model predicts each odebrano pulse
// and the held outputs; a per-cycle compare process checks them against the DUT.
module tb_uart_odbiornik;

    localparam int T = 16;
`ifdef UART_ODB_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       linia = 1'b1;
    logic       czy = 1'b0;
    logic       jaki = 1'b0;
    logic [7:0] slowo;
    logic       odebrano;
    logic       bp;
    logic       br;
    logic       odbior;

    uart_odbiornik #(.TAKTY_NA_BIT(T)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wejscie_odb(linia),
        .i_czy_parz   (czy),
        .i_jaki_parz  (jaki),
        .o_slowo_odb  (slowo),
        .o_odebrano   (odebrano),
        .o_blad_parz  (bp),
        .o_blad_ramki (br),
        .o_odbior     (odbior)
    );

    always #5 clk = ~clk;

    int cyk = 0;
    always @(posedge clk) cyk <= cyk + 1;

    int liczba_spr = 0;
    int bledy = 0;

    typedef struct {
        int         czas;
        logic [7:0] slowo;
        logic       bp;
        logic       br;
    } ramka_t;

    ramka_t     kolejka[$];
    int         impulsy[$];
    logic [7:0] m_slowo = 8'h00;
    logic       m_bp = 1'b0;
    logic       m_br = 1'b0;
    logic       c_puls;
    int         c0;
    int         c1;

    task automatic sprawdz(input string nazwa, input logic [31:0] akt, input logic [31:0] ocz);
        liczba_spr++;
        if (akt !== ocz) begin
            bledy++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nazwa, akt, ocz, cyk);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            c_puls = (kolejka.size() > 0) && (kolejka[0].czas == cyk);
            if (c_puls) begin
                m_slowo = kolejka[0].slowo;
                m_bp    = kolejka[0].bp;
                m_br    = kolejka[0].br;
                void'(kolejka.pop_front());
            end
            if (odebrano === 1'b1) impulsy.push_back(cyk);
            sprawdz("odebrano", {31'd0, odebrano}, {31'd0, c_puls});
            sprawdz("slowo_odb", {24'd0, slowo}, {24'd0, m_slowo});
            sprawdz("blad_parz", {31'd0, bp}, {31'd0, m_bp});
            sprawdz("blad_ramki", {31'd0, br}, {31'd0, m_br});
        end
    end

    task automatic pauza(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a whole frame starting now; the stop bit level is left on the line.
    task automatic nadaj_ramke(input logic [7:0] b, input logic pen, input logic pbit,
                               input logic jp, input logic stopb, output int start);
        ramka_t r;
        int     jedynki;
        czy     = pen;
        jaki    = jp;
        linia   = 1'b0;
        start   = cyk;
        jedynki = $countones(b) + (pen ? int'(pbit) : 0);
        r.czas  = start + ((19 + 2 * int'(pen)) * T) / 2 + S + 1;
        r.slowo = b;
        r.bp    = pen && ((jedynki % 2) != (jp ? 0 : 1));
        r.br    = ~stopb;
        kolejka.push_back(r);
        pauza(T);
        czy  = ~pen;
        jaki = ~jp;
        for (int i = 0; i < 8; i++) begin
            linia = b[i];
            pauza(T);
        end
        if (pen) begin
            linia = pbit;
            pauza(T);
        end
        linia = stopb;
        pauza(T);
    endtask

    initial begin
        pauza(3);
        rst = 1'b0;
        pauza(2);
        sprawdz("reset odbior", {31'd0, odbior}, 32'd0);
        sprawdz("reset slowo", {24'd0, slowo}, 32'h00);
        pauza(2 * T);

        // Even parity, correct parity bit; latency pinned by hand
        impulsy.delete();
        nadaj_ramke(8'h99, 1'b1, 1'b0, 1'b1, 1'b1, c0);
        pauza(T);
        sprawdz("0x99 pulse count", impulsy.size(), 32'd1);
        if (impulsy.size() > 0)
            sprawdz("0x99 latency", impulsy[0] - c0, (S == 2) ? 32'd171 : 32'd169);
        sprawdz("0x99 byte", {24'd0, slowo}, 32'h99);
        sprawdz("0x99 parity ok", {31'd0, bp}, 32'd0);

        // Same frame, wrong parity bit
        nadaj_ramke(8'h99, 1'b1, 1'b1, 1'b1, 1'b1, c0);
        pauza(T);
        sprawdz("0x99 parity err", {31'd0, bp}, 32'd1);
        sprawdz("0x99 frame ok", {31'd0, br}, 32'd0);

        // Stop bit low, line held low afterwards
        nadaj_ramke(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, c0);
        pauza(40);
        sprawdz("0x5A framing err", {31'd0, br}, 32'd1);
        sprawdz("0x5A byte", {24'd0, slowo}, 32'h5A);
        sprawdz("busy while line low", {31'd0, odbior}, 32'd1);
        linia = 1'b1;
        pauza(S);
        sprawdz("busy until line seen high", {31'd0, odbior}, 32'd1);
        pauza(1);
        sprawdz("idle after line high", {31'd0, odbior}, 32'd0);
        pauza(2 * T);

        // Reset in the middle of data bit 3 of 0x77, then a clean 0x3C
        impulsy.delete();
        czy   = 1'b0;
        linia = 1'b0;
        pauza(T);
        for (int i = 0; i < 3; i++) begin
            linia = ((8'h77 >> i) & 8'h01) != 8'h00;
            pauza(T);
        end
        linia = 1'b0;
        pauza(T / 2);
        sprawdz("busy before reset", {31'd0, odbior}, 32'd1);
        rst   = 1'b1;
        linia = 1'b1;
        kolejka.delete();
        m_slowo = 8'h00;
        m_bp    = 1'b0;
        m_br    = 1'b0;
        pauza(1);
        rst = 1'b0;
        sprawdz("after reset odbior", {31'd0, odbior}, 32'd0);
        sprawdz("after reset slowo", {24'd0, slowo}, 32'h00);
        sprawdz("after reset blad_ramki", {31'd0, br}, 32'd0);
        pauza(2 * T);
        nadaj_ramke(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        pauza(T);
        sprawdz("0x3C pulse count", impulsy.size(), 32'd1);
        sprawdz("0x3C byte", {24'd0, slowo}, 32'h3C);
        pauza(2 * T);

        // Short low glitch: false start rejected at the start mid-point
        impulsy.delete();
        linia = 1'b0;
        c0 = cyk;
        pauza(5);
        linia = 1'b1;
        pauza(S + T / 2 - 5);
        sprawdz("glitch busy before sample", {31'd0, odbior}, 32'd1);
        pauza(1);
        sprawdz("glitch idle after sample", {31'd0, odbior}, 32'd0);
        pauza(2 * T);
        sprawdz("glitch no pulse", impulsy.size(), 32'd0);

        // Odd parity: 0x00 with parity bit 0 is wrong, 0x01 with parity bit 0 is right
        nadaj_ramke(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, c0);
        pauza(T);
        sprawdz("odd 0x00 parity err", {31'd0, bp}, 32'd1);
        nadaj_ramke(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, c0);
        pauza(T);
        sprawdz("odd 0x01 parity ok", {31'd0, bp}, 32'd0);
        pauza(T);

        // Back-to-back frames with no idle gap
        impulsy.delete();
        nadaj_ramke(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        nadaj_ramke(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, c1);
        pauza(T);
        sprawdz("b2b pulse count", impulsy.size(), 32'd2);
        if (impulsy.size() == 2)
            sprawdz("b2b spacing", impulsy[1] - impulsy[0], 32'd160);
        sprawdz("b2b last byte", {24'd0, slowo}, 32'h0F);

        pauza(2 * T);
        sprawdz("no pending frames", kolejka.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", liczba_spr, bledy);
        $finish;
    end

endmodule
